// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: R-type funct codes for HI/LO ops and the mul/div FSM states.
package mips_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX
  } md_state_t;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// E-stage <-> mul/div unit signals; the pipeline is master, the unit is slave.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             ValidE;
  logic [5:0]       FunctE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             FlushE;
  logic             StallE;
  logic [WIDTH-1:0] HiLoOutE;
  logic             BusyE;

  modport master (output ValidE, FunctE, SrcAE, SrcBE, FlushE,
                  input  StallE, HiLoOutE, BusyE);
  modport slave  (input  ValidE, FunctE, SrcAE, SrcBE, FlushE,
                  output StallE, HiLoOutE, BusyE);
endinterface

// File: rtl/muldiv_iter.sv
// Shared shift datapath: radix-2 shift-add multiply or restoring divide on unsigned magnitudes,
// one bit per step; acc_hi/acc_lo hold {product} or {remainder, quotient} after WIDTH steps.
module muldiv_iter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             mul_mode,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_op,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   add_a, sum;

  // One adder serves both modes: hi+multiplicand, or {rem,next dividend bit}-divisor.
  always_comb begin
    add_a = mul_mode ? {1'b0, hi_q} : {hi_q, lo_q[WIDTH-1]};
    sum   = mul_mode ? add_a + {1'b0, op_q} : add_a - {1'b0, op_q};
    hi_d  = hi_q;
    lo_d  = lo_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = load_lo;
      op_d  = load_op;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (mul_mode) begin
        if (lo_q[0]) {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end else if (!sum[WIDTH]) begin
        hi_d = sum[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = add_a[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;
  assign last   = step && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// MIPS E-stage multiply/divide unit with HI/LO: WIDTH iteration cycles + 1 sign-fix cycle,
// stalls only HI/LO-class instructions while busy; FlushE aborts without touching HI/LO.
module muldiv_unit import mips_pkg::*; #(parameter int WIDTH = 32) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave md
);
  md_state_t        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_mul_q, is_mul_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d, div0_q, div0_d;

  logic             md_funct, busy, stall, accept, op_mul, op_div, op_signed;
  logic             a_neg, b_neg, iter_last;
  logic [WIDTH-1:0] a_mag, b_mag, acc_hi, acc_lo, quo, rem;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign md_funct  = is_md_funct(md.FunctE);
  assign busy      = (state_q != MD_IDLE);
  assign stall     = busy & md.ValidE & md_funct;
  assign accept    = md.ValidE & md_funct & ~stall & ~md.FlushE;
  assign op_mul    = (md.FunctE == F_MULT) || (md.FunctE == F_MULTU);
  assign op_div    = (md.FunctE == F_DIV)  || (md.FunctE == F_DIVU);
  assign op_signed = (md.FunctE == F_MULT) || (md.FunctE == F_DIV);
  assign a_neg     = op_signed & md.SrcAE[WIDTH-1];
  assign b_neg     = op_signed & md.SrcBE[WIDTH-1];
  assign a_mag     = a_neg ? -md.SrcAE : md.SrcAE;
  assign b_mag     = b_neg ? -md.SrcBE : md.SrcBE;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept & (op_mul | op_div)),
    .step     ((state_q == MD_MUL) || (state_q == MD_DIV)),
    .mul_mode (state_q == MD_MUL),
    .load_lo  (op_mul ? b_mag : a_mag),
    .load_op  (op_mul ? a_mag : b_mag),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .last     (iter_last)
  );

  // Magnitude results are sign-corrected here; the most-negative / -1 case falls out naturally.
  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_p_q ? -prod : prod;
  assign quo    = neg_p_q ? -acc_lo : acc_lo;
  assign rem    = neg_r_q ? -acc_hi : acc_hi;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_mul_d = is_mul_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          case (md.FunctE)
            F_MTHI: hi_d = md.SrcAE;
            F_MTLO: lo_d = md.SrcAE;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d  = op_mul ? MD_MUL : MD_DIV;
              is_mul_d = op_mul;
              neg_p_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              div0_d   = op_div & (md.SrcBE == '0);
            end
            default: ;
          endcase
        end
      end
      MD_MUL, MD_DIV: begin
        if (md.FlushE)      state_d = MD_IDLE;
        else if (iter_last) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!md.FlushE) begin
          if (is_mul_q) begin
            {hi_d, lo_d} = prod_s;
          end else begin
            // Remainder of x/0 is |x| re-signed, i.e. x itself.
            hi_d = rem;
            lo_d = div0_q ? '1 : quo;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MD_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      is_mul_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_mul_q <= is_mul_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
    end
  end

  assign md.StallE   = stall;
  assign md.BusyE    = busy;
  assign md.HiLoOutE = (md.FunctE == F_MFHI) ? hi_q :
                       (md.FunctE == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit at WIDTH=32, plus a WIDTH=8 instance for the narrow multiply case.
module tb_muldiv_unit;
  import mips_pkg::*;

  localparam logic [5:0] F_ADD = 6'b100000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) m32 ();
  muldiv_unit_if #(.WIDTH(8))  m8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .md(m32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .md(m8));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of HI/LO for each op, computed with native SV arithmetic.
  task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (f)
      F_MTHI:  mdl_hi = a;
      F_MTLO:  mdl_lo = a;
      F_MULT:  begin p = longint'(sa) * longint'(sb); {mdl_hi, mdl_lo} = p; end
      F_MULTU: begin up = {32'h0, a} * {32'h0, b}; {mdl_hi, mdl_lo} = up; end
      F_DIV: begin
        if (b == 32'h0)                                 begin mdl_hi = a; mdl_lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mdl_hi = '0; mdl_lo = a; end
        else begin mdl_lo = sa / sb; mdl_hi = sa % sb; end
      end
      F_DIVU: begin
        if (b == 32'h0) begin mdl_hi = a; mdl_lo = '1; end
        else begin mdl_lo = a / b; mdl_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  // Holds the instruction in E until the unit stops stalling it; returns the stall count.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    bit ok = 0;
    m32.ValidE = 1'b1; m32.FunctE = f; m32.SrcAE = a; m32.SrcBE = b;
    stalls = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!m32.StallE) ok = 1;
      else stalls++;
      tick();
    end
    m32.ValidE = 1'b0; m32.FunctE = F_ADD;
    if (!ok) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic read_hilo(input logic [5:0] f, input string tag, output int stalls, output int busyc);
    bit ok = 0;
    logic [31:0] exp;
    sb_q.push_back((f == F_MFHI) ? mdl_hi : mdl_lo);
    m32.ValidE = 1'b1; m32.FunctE = f;
    stalls = 0;
    busyc = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (m32.BusyE) busyc++;
      if (!m32.StallE) begin
        exp = sb_q.pop_front();
        chk(tag, m32.HiLoOutE, exp);
        ok = 1;
      end else stalls++;
      tick();
    end
    m32.ValidE = 1'b0; m32.FunctE = F_ADD;
    if (!ok) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic op_and_read(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                             input string tag);
    int st, bc;
    issue(f, a, b, st);
    model_op(f, a, b);
    read_hilo(F_MFHI, {tag, "_hi"}, st, bc);
    read_hilo(F_MFLO, {tag, "_lo"}, st, bc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, bc;
    logic [5:0] fr;
    logic [5:0] rand_ops [4];
    rand_ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

    m32.ValidE = 0; m32.FunctE = F_MFHI; m32.SrcAE = '0; m32.SrcBE = '0; m32.FlushE = 0;
    m8.ValidE  = 0; m8.FunctE  = F_MFHI; m8.SrcAE  = '0; m8.SrcBE  = '0; m8.FlushE  = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", m32.BusyE, 0);
    chk("rst_stall", m32.StallE, 0);
    chk("rst_hi", m32.HiLoOutE, 0);
    chk("rst_busy8", m8.BusyE, 0);
    m32.FunctE = F_MFLO;
    #1 chk("rst_lo", m32.HiLoOutE, 0);
    tick();

    // MULT then an immediately following MFHI that must wait out the full latency.
    issue(F_MULT, 32'hFFFF_FFFF, 32'h0000_0002, st);
    chk("mult_issue_stall", st, 0);
    model_op(F_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    read_hilo(F_MFHI, "mult_hi", st, bc);
    chk("mult_mfhi_stalls", st, 33);
    chk("mult_busy_cycles", bc, 33);
    read_hilo(F_MFLO, "mult_lo", st, bc);
    chk("mult_lo_no_stall", st, 0);

    op_and_read(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");

    // Unrelated instruction in E during a DIV proceeds.
    issue(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, st);
    model_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    m32.ValidE = 1'b1; m32.FunctE = F_ADD;
    @(negedge clk);
    chk("add_during_div_stall", m32.StallE, 0);
    chk("add_during_div_busy", m32.BusyE, 1);
    tick();
    m32.ValidE = 1'b0;
    read_hilo(F_MFLO, "div_neg_lo", st, bc);
    read_hilo(F_MFHI, "div_neg_hi", st, bc);

    issue(F_DIVU, 32'h0000_0007, 32'h0000_0000, st);
    model_op(F_DIVU, 32'h0000_0007, 32'h0000_0000);
    read_hilo(F_MFLO, "divu0_lo", st, bc);
    chk("divu0_full_latency", st, 33);
    read_hilo(F_MFHI, "divu0_hi", st, bc);

    op_and_read(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    op_and_read(F_DIV, 32'h8000_0000, 32'h0000_0000, "div_minneg_by0");

    issue(F_MTHI, 32'h0000_1234, 32'h0, st);
    model_op(F_MTHI, 32'h0000_1234, 32'h0);
    read_hilo(F_MFHI, "mthi", st, bc);
    chk("mthi_no_stall", st, 0);
    op_and_read(F_MTLO, 32'hCAFE_F00D, 32'h0, "mtlo");

    // Second op behind a busy one is accepted in cycle WIDTH+2.
    issue(F_MULT, 32'h0001_0003, 32'hFFFF_FFF0, st);
    model_op(F_MULT, 32'h0001_0003, 32'hFFFF_FFF0);
    issue(F_DIVU, 32'h0000_0064, 32'h0000_0007, st);
    chk("b2b_stall", st, 33);
    model_op(F_DIVU, 32'h0000_0064, 32'h0000_0007);
    read_hilo(F_MFHI, "b2b_hi", st, bc);
    read_hilo(F_MFLO, "b2b_lo", st, bc);

    // Flush at cycle 10 of a MULT leaves HI/LO untouched.
    issue(F_MULT, 32'h0000_0003, 32'h0000_0005, st);
    repeat (9) tick();
    m32.FlushE = 1'b1;
    @(negedge clk);
    chk("flush_busy_k", m32.BusyE, 1);
    tick();
    m32.FlushE = 1'b0;
    @(negedge clk);
    chk("flush_busy_k1", m32.BusyE, 0);
    tick();
    read_hilo(F_MFHI, "flush_hi", st, bc);
    chk("flush_no_stall", st, 0);
    read_hilo(F_MFLO, "flush_lo", st, bc);

    // Flush in the issue cycle blocks acceptance.
    m32.ValidE = 1'b1; m32.FunctE = F_DIVU; m32.SrcAE = 32'h55; m32.SrcBE = 32'h3; m32.FlushE = 1'b1;
    tick();
    m32.ValidE = 1'b0; m32.FlushE = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept", m32.BusyE, 0);
    tick();

    for (int i = 0; i < 6; i++) begin
      fr = rand_ops[$urandom_range(0, 3)];
      op_and_read(fr, $urandom, (i % 2) ? $urandom_range(1, 300) : $urandom, $sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-DIV.
    issue(F_DIV, 32'h1234_5678, 32'h0000_0013, st);
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_busy", m32.BusyE, 0);
    m32.FunctE = F_MFHI;
    #1 chk("rst_mid_hi", m32.HiLoOutE, 0);
    m32.FunctE = F_MFLO;
    #1 chk("rst_mid_lo", m32.HiLoOutE, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mdl_hi = '0; mdl_lo = '0;
    tick();
    read_hilo(F_MFLO, "post_rst_lo", st, bc);
    chk("post_rst_no_stall", st, 0);

    // WIDTH=8 instance.
    m8.ValidE = 1'b1; m8.FunctE = F_MULT; m8.SrcAE = 8'h80; m8.SrcBE = 8'h80;
    @(negedge clk);
    chk("w8_issue_stall", m8.StallE, 0);
    tick();
    m8.ValidE = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m8.BusyE) break;
      bc++;
      tick();
    end
    chk("w8_busy_cycles", bc, 9);
    m8.FunctE = F_MFHI;
    #1 chk("w8_hi", m8.HiLoOutE, 8'h40);
    m8.FunctE = F_MFLO;
    #1 chk("w8_lo", m8.HiLoOutE, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
